// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// State encoding and counter sizing live here.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_if.sv
// Start/done handshake bundle for the divider.
// Master drives operands, slave returns results.
interface divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  done,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output done,
    output quotient,
    output remainder
  );

endinterface

// File: rtl/divider_step.sv
// One restoring iteration: shift in a dividend bit,
// trial-subtract the divisor, restore on borrow.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // Extra top bit exposes the borrow of the trial subtract.
  always_comb begin
    sh     = {rem_i, bit_i};
    diff   = sh - {1'b0, dvs_i};
    qbit_o = ~diff[WIDTH];
    rem_o  = diff[WIDTH] ? sh[WIDTH-1:0]
                         : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider, one
// quotient bit per clock, start/done handshake.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  divider_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             done_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             qbit;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (rem_d),
    .qbit_o (qbit)
  );

  // Dividend shifts out the top while quotient bits fill the bottom.
  assign dvd_d = {dvd_q[WIDTH-2:0], qbit};

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            rem_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_q   <= dvd_d;
            rmd_q   <= rem_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider with
// a result queue filled at drive time.
module tb_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  divider_if #(.WIDTH(W)) bus_if ();

  divider #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Runs one operation; optionally pulses start again mid-flight.
  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit inject);
    int   cyc;
    exp_t e;
    logic [63:0] prod;
    sb.push_back(model(a, b));
    bus_if.start    = 1'b1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    tick();
    bus_if.start    = 1'b0;
    bus_if.dividend = $urandom;
    bus_if.divisor  = $urandom;
    cyc = 0;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      if (inject && cyc == 5) begin
        bus_if.start    = 1'b1;
        bus_if.dividend = 32'd999;
        bus_if.divisor  = 32'd3;
      end else begin
        bus_if.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus_if.start = 1'b0;
    chk({tag, "_done"}, 64'(bus_if.done), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'd32);
    e = sb.pop_front();
    chk({tag, "_q"}, 64'(bus_if.quotient), 64'(e.q));
    chk({tag, "_r"}, 64'(bus_if.remainder), 64'(e.r));
    if (e.b != '0) begin
      prod = 64'(bus_if.quotient) * 64'(e.b)
           + 64'(bus_if.remainder);
      chk({tag, "_inv"}, prod, 64'(e.a));
      chk({tag, "_rlt"},
          64'(bus_if.remainder < e.b), 64'd1);
    end
    tick();
    chk({tag, "_fall"}, 64'(bus_if.done), 64'd0);
    chk({tag, "_hq"}, 64'(bus_if.quotient), 64'(e.q));
    chk({tag, "_hr"}, 64'(bus_if.remainder), 64'(e.r));
  endtask

  initial begin
    int hits;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    repeat (3) tick();
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_q", 64'(bus_if.quotient), 64'd0);
    chk("rst_r", 64'(bus_if.remainder), 64'd0);
    rst = 1'b0;
    tick();

    run_op("d10_7", 32'd10, 32'd7, 1'b0);
    tick();
    run_op("d100_100", 32'd100, 32'd100, 1'b0);
    tick();
    run_op("d100_7", 32'd100, 32'd7, 1'b0);
    tick();
    run_op("d100_0", 32'd100, 32'd0, 1'b0);
    tick();
    run_op("d70_150", 32'd70, 32'd150, 1'b0);
    tick();
    run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    run_op("dmax_max", 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 1'b0);
    tick();
    run_op("inject", 32'd12345, 32'd17, 1'b1);
    tick();
    run_op("pre_abort", 32'd100, 32'd7, 1'b0);
    tick();

    // Abort an operation partway with an async reset.
    bus_if.start    = 1'b1;
    bus_if.dividend = 32'd5000;
    bus_if.divisor  = 32'd9;
    tick();
    bus_if.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("abort_done", 64'(bus_if.done), 64'd0);
    chk("abort_q", 64'(bus_if.quotient), 64'd0);
    chk("abort_r", 64'(bus_if.remainder), 64'd0);
    tick();
    rst  = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_if.done === 1'b1) hits++;
    end
    chk("abort_nodone", 64'(hits), 64'd0);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom >> (i * 4);
      if (b == '0) b = 32'd3;
      run_op("rand", a, b, 1'b0);
      tick();
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle unsigned integer divider using the restoring shift-subtract algorithm, one quotient bit per clock.
- Accepts a one-cycle start pulse with dividend/divisor and returns quotient and remainder with a one-cycle done pulse.
- Used as a shared arithmetic resource behind a simple start/done handshake; a single operation is in flight at a time.

Parameters:
- WIDTH, 32, operand and result width in bits (WIDTH >= 2).

Ports:
- clk        input   1      system clock; all state updates on rising edge
- rst        input   1      asynchronous reset, active high
- start      input   1      request pulse; operands sampled when start=1 in IDLE
- dividend   input   WIDTH  unsigned dividend
- divisor    input   WIDTH  unsigned divisor
- done       output  1      one-cycle pulse; results valid
- quotient   output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder

Behaviour:
- Reset (asynchronous, active high): state=IDLE; done=0, quotient=0, remainder=0; internal counter and working registers cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on a rising edge with start=1 (edge E0):
  - latch dividend into a shift register and divisor into a holding register;
  - clear the partial remainder;
  - set the iteration count to WIDTH;
  - go to BUSY.
  - start=0 in IDLE: no action.
- BUSY: each edge performs one iteration:
  - shift the partial remainder left by 1, bringing in the dividend MSB;
  - trial-subtract the divisor at WIDTH+1 bits;
  - if no borrow, keep the difference and shift quotient bit 1 in; else restore and shift 0 in;
  - decrement the count.
  - WIDTH iterations run at edges E1..E_WIDTH; at E_WIDTH, load quotient/remainder outputs, set done=1 and go to DONE.
- DONE: lasts exactly one cycle; at the next edge done=0 and state returns to IDLE.
- Latency: done is high during the cycle after edge E_WIDTH (32 cycles after the start-sampling edge for WIDTH=32).
  - A new start is accepted no earlier than one cycle after done falls (IDLE).
- quotient/remainder:
  - update only when done is asserted;
  - hold their values until the next operation completes;
  - are not disturbed during BUSY.
- start while BUSY or DONE: ignored; operands are not re-sampled.
  - dividend/divisor may change freely after the sampling edge.
- Divide by zero: no special path. The algorithm naturally yields quotient = all ones (2^WIDTH-1) and remainder = dividend; done timing is unchanged.
- Dividend < divisor: quotient=0, remainder=dividend.
- Invariant for divisor != 0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Reset mid-operation: immediately aborts; back to IDLE with outputs cleared, no done pulse.

Decomposition:
- Shared package: state enum (IDLE/BUSY/DONE), default WIDTH constant, counter width $clog2(WIDTH+1).
- Optional sub-module div_step: combinational one-iteration shift/trial-subtract cell, instantiated once. Otherwise a single flat module.

Test Plan:
- Operation 10/7 after reset -> done one cycle, exactly 32 cycles after the start edge; quotient=1, remainder=3.
- Operation 100/100 -> quotient=1, remainder=0; outputs held after done falls.
- Operation 100/7 -> quotient=14, remainder=2.
- Operation 100/0 -> quotient=32'hFFFFFFFF, remainder=100, normal latency.
- Operation 70/150 -> quotient=0, remainder=70.
- Robustness:
  - pulse start again mid-operation -> ignored, original result returned;
  - assert rst at cycle 10 of an operation -> no done, outputs 0;
  - random 32-bit pairs -> invariant holds.
